// File: rtl/ad_block_feeder.sv
// Packs a byte-serial AD stream big-endian into 64-bit ASCON rate blocks with 10* padding,
// presenting one block at a time to the AD sequencer.
//
// Handshake semantics: a byte moves when in_valid & in_ready are both high at a rising clk edge.
// in_ready is combinational. It may depend on in_last and blk_read, because a closing byte can
// only be taken when the output slot is empty or is being popped in the same cycle.
// A block is consumed when blk_read & blk_valid are both high at a rising edge.
module ad_block_feeder #(
  parameter int MAX_AD_BYTES = 16
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic        clear,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  input  logic        blk_read,
  output logic        blk_valid,
  output logic [63:0] blk_data,
  output logic [3:0]  blk_len,
  output logic        blk_last,
  output logic [4:0]  ad_len,
  output logic        ad_done,
  output logic        err_overflow,
  output logic        err_underrun,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_PAD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [4:0]  MAX_L   = 5'(MAX_AD_BYTES);
  localparam logic [63:0] PAD_BLK = 64'h8000_0000_0000_0000;

  state_t      state, state_next;
  logic [63:0] fill;
  logic [3:0]  cnt;
  logic [4:0]  len_q;
  logic [63:0] slot_data;
  logic [3:0]  slot_len;
  logic        slot_last;
  logic        slot_valid;
  logic        ovf_q, unf_q;

  logic        slot_free;
  logic        pop;
  logic        closing_byte;
  logic        accept;
  logic        close;
  logic        pad_load;
  logic        load;
  logic [63:0] with_byte;
  logic [63:0] padded;
  logic [63:0] load_data;
  logic [3:0]  load_len;
  logic        load_last;

  // State register
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state <= S_FILL;
    end else if (clear) begin
      state <= S_FILL;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_FILL: begin
        if (close && in_last) begin
          state_next = (cnt == 4'd7) ? S_PAD : S_DONE;
        end
      end
      S_PAD: begin
        if (slot_free) begin
          state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_DONE;
      default: state_next = S_FILL;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready  = 1'b0;
    ad_done   = 1'b0;
    dbg_state = state;
    case (state)
      S_FILL: in_ready = (len_q < MAX_L) && (!closing_byte || slot_free);
      S_PAD:  ad_done  = 1'b1;
      S_DONE: ad_done  = 1'b1;
      default: begin
        in_ready = 1'b0;
        ad_done  = 1'b0;
      end
    endcase
  end

  assign slot_free    = !slot_valid || blk_read;
  assign pop          = blk_read && slot_valid;
  assign closing_byte = (cnt == 4'd7) || in_last;
  assign accept       = in_valid && in_ready;
  assign close        = accept && closing_byte;
  assign pad_load     = (state == S_PAD) && slot_free;
  assign load         = close || pad_load;

  // Drop the incoming byte into its lane, then mark the 10* pad byte just after it.
  always_comb begin
    with_byte = fill;
    for (int i = 0; i < 8; i++) begin
      if (cnt == 4'(i)) begin
        with_byte[63-8*i -: 8] = in_data;
      end
    end
    padded = with_byte;
    for (int i = 0; i < 7; i++) begin
      if (cnt == 4'(i)) begin
        padded[55-8*i -: 8] = 8'h80;
      end
    end
  end

  always_comb begin
    if (pad_load) begin
      load_data = PAD_BLK;
      load_len  = 4'd0;
      load_last = 1'b1;
    end else begin
      load_data = padded;
      load_len  = cnt + 4'd1;
      load_last = in_last && (cnt != 4'd7);
    end
  end

  // Fill register, byte count and message length
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      fill  <= '0;
      cnt   <= '0;
      len_q <= '0;
    end else if (clear) begin
      fill  <= '0;
      cnt   <= '0;
      len_q <= '0;
    end else if (accept) begin
      len_q <= len_q + 5'd1;
      if (close) begin
        fill <= '0;
        cnt  <= '0;
      end else begin
        fill <= with_byte;
        cnt  <= cnt + 4'd1;
      end
    end
  end

  // Output slot: a reload on the same edge as a pop keeps blk_valid high.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      slot_data  <= '0;
      slot_len   <= '0;
      slot_last  <= 1'b0;
      slot_valid <= 1'b0;
    end else if (clear) begin
      slot_data  <= '0;
      slot_len   <= '0;
      slot_last  <= 1'b0;
      slot_valid <= 1'b0;
    end else if (load) begin
      slot_data  <= load_data;
      slot_len   <= load_len;
      slot_last  <= load_last;
      slot_valid <= 1'b1;
    end else if (pop) begin
      slot_data  <= '0;
      slot_len   <= '0;
      slot_last  <= 1'b0;
      slot_valid <= 1'b0;
    end
  end

  // Sticky error flags
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (clear) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (in_valid && (state == S_FILL) && (len_q == MAX_L)) begin
        ovf_q <= 1'b1;
      end
      if (blk_read && !slot_valid) begin
        unf_q <= 1'b1;
      end
    end
  end

  assign blk_valid    = slot_valid;
  assign blk_data     = slot_valid ? slot_data : 64'h0;
  assign blk_len      = slot_valid ? slot_len : 4'd0;
  assign blk_last     = slot_valid && slot_last;
  assign ad_len       = len_q;
  assign err_overflow = ovf_q;
  assign err_underrun = unf_q;

endmodule

// File: tb/tb_ad_block_feeder.sv
// Bench for ad_block_feeder: directed scenarios plus randomized messages, checked every cycle
// against a byte-list model that builds the expected padded blocks from whole messages.
module tb_ad_block_feeder;

  localparam int MAX = 16;

  logic        clk = 1'b0;
  logic        nRST = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic        blk_read = 1'b0;
  logic        blk_valid;
  logic [63:0] blk_data;
  logic [3:0]  blk_len;
  logic        blk_last;
  logic [4:0]  ad_len;
  logic        ad_done;
  logic        err_overflow;
  logic        err_underrun;
  logic [1:0]  dbg_state;

  ad_block_feeder #(.MAX_AD_BYTES(MAX)) dut (
    .clk(clk), .nRST(nRST), .clear(clear),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .blk_read(blk_read), .blk_valid(blk_valid), .blk_data(blk_data), .blk_len(blk_len),
    .blk_last(blk_last), .ad_len(ad_len), .ad_done(ad_done),
    .err_overflow(err_overflow), .err_underrun(err_underrun), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [68:0] got, input logic [68:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: expected blocks as {last, len[3:0], data[63:0]}
  logic [68:0] exp_q[$];
  logic [7:0]  cur_q[$];
  int          m_cnt;
  bit          m_done, m_ovf, m_unf;

  function automatic void model_reset();
    exp_q.delete();
    cur_q.delete();
    m_cnt  = 0;
    m_done = 1'b0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endfunction

  function automatic void model_push(input logic [7:0] b, input logic l);
    logic [63:0] d;
    int          n;
    cur_q.push_back(b);
    m_cnt++;
    if (l) m_done = 1'b1;
    if (cur_q.size() == 8 || l) begin
      n = cur_q.size();
      d = '0;
      for (int i = 0; i < n; i++) d[63-8*i -: 8] = cur_q[i];
      if (n < 8) d[63-8*n -: 8] = 8'h80;
      exp_q.push_back({(l && n < 8), 4'(n), d});
      if (l && n == 8) exp_q.push_back({1'b1, 4'd0, 64'h8000_0000_0000_0000});
      cur_q.delete();
    end
  endfunction

  // Monitor: compare registered outputs with the model, then apply this cycle's events.
  always @(negedge clk) begin
    if (!nRST) begin
      model_reset();
    end else begin
      bit exp_rdy;
      check("blk_valid", 69'(blk_valid), 69'(exp_q.size() != 0));
      if (exp_q.size() != 0) check("blk", {blk_last, blk_len, blk_data}, exp_q[0]);
      else check("blk_idle", {blk_last, blk_len, blk_data}, 69'h0);
      check("ad_len", 69'(ad_len), 69'(m_cnt));
      check("ad_done", 69'(ad_done), 69'(m_done));
      check("err_overflow", 69'(err_overflow), 69'(m_ovf));
      check("err_underrun", 69'(err_underrun), 69'(m_unf));
      exp_rdy = !m_done && (m_cnt < MAX) &&
                !((in_last || cur_q.size() == 7) && exp_q.size() != 0 && !blk_read);
      check("in_ready", 69'(in_ready), 69'(exp_rdy));
      if (clear) begin
        model_reset();
      end else begin
        if (blk_read && exp_q.size() == 0) m_unf = 1'b1;
        if (in_valid && !m_done && m_cnt == MAX) m_ovf = 1'b1;
        if (blk_read && exp_q.size() != 0) void'(exp_q.pop_front());
        if (in_valid && in_ready) model_push(in_data, in_last);
      end
    end
  end

  // Driver tasks: called at posedge+1, drive one cycle, sample acceptance at negedge.
  // rmode: 0 no read, 1 random read when valid, 2 read when valid, 3 read unconditionally.
  task automatic cyc(input bit v, input logic [7:0] d, input bit l, input int rmode, output bit acc);
    in_valid = v;
    in_data  = v ? d : 8'h00;
    in_last  = v && l;
    case (rmode)
      0:       blk_read = 1'b0;
      1:       blk_read = blk_valid && ($urandom_range(0, 1) == 1);
      2:       blk_read = blk_valid;
      default: blk_read = 1'b1;
    endcase
    @(negedge clk);
    acc = v && in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input int rmode);
    bit acc;
    for (int k = 0; k < n; k++) cyc(1'b0, 8'h00, 1'b0, rmode, acc);
  endtask

  task automatic send(input logic [7:0] d, input bit l, input int rmode, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) cyc(1'b1, d, l, rmode, ok);
  endtask

  task automatic do_clear();
    bit acc;
    clear = 1'b1;
    cyc(1'b0, 8'h00, 1'b0, 0, acc);
    clear = 1'b0;
  endtask

  task automatic send_msg(input logic [7:0] base, input int n, input bit with_last, input int rmode,
                          input string tag);
    bit ok;
    for (int i = 1; i <= n; i++) begin
      send(base + 8'(i), with_last && (i == n), rmode, 10, ok);
      check(tag, 69'(ok), 69'(1));
    end
  endtask

  initial begin
    bit ok;
    int len;
    int guard;

    repeat (3) @(posedge clk);
    #1;
    nRST = 1'b1;
    check("rst_blk", {blk_valid, blk_last, blk_len, blk_data}, 69'h0);
    check("rst_status", {64'h0, ad_len, ad_done, err_overflow, err_underrun}, 69'h0);

    // T1: short message, single padded block with latency 1
    send_msg(8'h00, 5, 1'b1, 0, "t1_send");
    check("t1_blk", {blk_last, blk_len, blk_data}, {1'b1, 4'd5, 64'h0102_0304_0580_0000});
    check("t1_ad_len", 69'(ad_len), 69'(5));
    check("t1_ad_done", 69'(ad_done), 69'(1));
    idle(1, 2);
    check("t1_popped", 69'(blk_valid), 69'(0));
    do_clear();

    // T2: full block followed by the all-padding block
    send_msg(8'h10, 8, 1'b1, 0, "t2_send");
    check("t2_blk0", {blk_last, blk_len, blk_data}, {1'b0, 4'd8, 64'h1112_1314_1516_1718});
    idle(1, 2);
    check("t2_blk1", {blk_last, blk_len, blk_data}, {1'b1, 4'd0, 64'h8000_0000_0000_0000});
    idle(1, 2);
    check("t2_end", {65'h0, blk_valid, ad_done, 2'b00}, {65'h0, 1'b0, 1'b1, 2'b00});
    do_clear();

    // T3: second close stalls while the slot is still full
    send_msg(8'h20, 11, 1'b0, 0, "t3_send");
    check("t3_blk0", {blk_last, blk_len, blk_data}, {1'b0, 4'd8, 64'h2122_2324_2526_2728});
    send(8'h2c, 1'b1, 0, 4, ok);
    check("t3_stall", 69'(ok), 69'(0));
    send(8'h2c, 1'b1, 2, 10, ok);
    check("t3_resume", 69'(ok), 69'(1));
    check("t3_blk1", {blk_last, blk_len, blk_data}, {1'b1, 4'd4, 64'h292A_2B2C_8000_0000});
    check("t3_ad_len", 69'(ad_len), 69'(12));
    idle(2, 2);
    do_clear();

    // T4: close and pop on the same edge
    send_msg(8'h30, 8, 1'b0, 0, "t4_send_a");
    send_msg(8'h38, 7, 1'b0, 0, "t4_send_b");
    send(8'h40, 1'b0, 2, 1, ok);
    check("t4_same_cycle", 69'(ok), 69'(1));
    check("t4_blk", {blk_valid, blk_last, blk_len, blk_data}, {1'b1, 1'b0, 4'd8, 64'h393A_3B3C_3D3E_3F40});
    check("t4_underrun", 69'(err_underrun), 69'(0));
    do_clear();

    // T5: byte beyond the maximum stalls and flags overflow
    send_msg(8'h50, MAX, 1'b0, 2, "t5_send");
    send(8'h61, 1'b1, 2, 4, ok);
    check("t5_stall", 69'(ok), 69'(0));
    check("t5_overflow", 69'(err_overflow), 69'(1));
    check("t5_ad_len", 69'(ad_len), 69'(MAX));
    idle(1, 2);
    do_clear();

    // T6: underrun, mid-message clear, zero-length message, clean restart
    idle(1, 3);
    check("t6_underrun", 69'(err_underrun), 69'(1));
    send_msg(8'h70, 10, 1'b0, 0, "t6_send");
    do_clear();
    check("t6_cleared", {blk_valid, blk_last, blk_len, blk_data},  69'h0);
    check("t6_cleared_st", {64'h0, ad_len, ad_done, err_overflow, err_underrun}, 69'h0);
    idle(5, 2);
    check("t6_zero_len", {64'h0, ad_len, ad_done, blk_valid, 1'b0}, 69'h0);
    send_msg(8'h00, 5, 1'b1, 0, "t6_restart");
    check("t6_blk", {blk_last, blk_len, blk_data}, {1'b1, 4'd5, 64'h0102_0304_0580_0000});
    idle(1, 2);
    do_clear();

    // Randomized messages with random gaps and pops
    for (int m = 0; m < 40; m++) begin
      len = $urandom_range(1, MAX);
      for (int i = 1; i <= len; i++) begin
        idle($urandom_range(0, 2), 1);
        send(8'($urandom), i == len, 1, 200, ok);
        check("rnd_send", 69'(ok), 69'(1));
      end
      guard = 0;
      while ((blk_valid || !ad_done) && guard < 100) begin
        idle(1, 1);
        guard++;
      end
      check("rnd_drain", {67'h0, ad_done, blk_valid}, {67'h0, 1'b1, 1'b0});
      check("rnd_model_empty", 69'(exp_q.size()), 69'(0));
      check("rnd_ad_len", 69'(ad_len), 69'(len));
      do_clear();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
